// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the write-back port arbiter.
package wb_arb_pkg;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned NUM_REGS   = 16;
    localparam logic [REG_ADDR_W-1:0] RA_REG = 4'b1111;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [31:0]           data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RW,
        GNT_LU
    } grant_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Long-latency result buffer; pointers carry one extra bit to tell full from empty.
module wb_result_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    wb_req_t     mem_q [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A full FIFO refuses pushes even while it is being popped.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the RW stage and buffered LU results.
// Optional statistics counters are enabled with `define WB_ARB_STATS_EN.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rw_is_wb,
    input  logic [3:0]  rw_rd,
    input  logic [31:0] rw_data,
    output logic        rw_hold,
    input  logic        lu_valid,
    input  logic [3:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        iss_valid,
    input  logic [3:0]  iss_rd,
    input  logic [3:0]  dec_rs1,
    input  logic [3:0]  dec_rs2,
    input  logic [3:0]  dec_rd,
    input  logic        dec_valid,
    output logic        dec_stall,
`ifdef WB_ARB_STATS_EN
    output logic [31:0] stat_hold_cnt,
    output logic [31:0] stat_full_cnt,
`endif
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [15:0] busy_mask
);

    localparam int unsigned SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = {{(SW-1){1'b0}}, 1'b1};

    wb_req_t       lu_req;
    wb_req_t       head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    grant_e        grant;

    logic [SW-1:0]         starve_q, starve_d;
    logic                  rf_we_q, rf_we_d;
    logic [3:0]            rf_waddr_q, rf_waddr_d;
    logic [31:0]           rf_wdata_q, rf_wdata_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    assign lu_req   = '{rd: lu_rd, data: lu_data};
    assign lu_ready = !fifo_full;
    assign push     = lu_valid && !fifo_full;
    assign pop      = (grant == GNT_LU);

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (lu_req),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Registered state only, so there is no path from rw_is_wb to rw_hold.
    assign rw_hold = (starve_q == STARVE_MAX) && !fifo_empty;

    always_comb begin
        grant = GNT_NONE;
        if (rw_hold) begin
            grant = GNT_LU;
        end else if (rw_is_wb) begin
            grant = GNT_RW;
        end else if (!fifo_empty) begin
            grant = GNT_LU;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || grant == GNT_LU) begin
            starve_d = '0;
        end else if (grant == GNT_RW && starve_q != STARVE_MAX) begin
            starve_d = starve_q + STARVE_ONE;
        end
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        unique case (grant)
            GNT_RW: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = rw_rd;
                rf_wdata_d = rw_data;
            end
            GNT_LU: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = head.rd;
                rf_wdata_d = head.data;
            end
            default: ;
        endcase
    end

    // Clear before set so a same-cycle issue to a retiring rd keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head.rd] = 1'b0;
        end
        if (iss_valid) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    assign dec_stall = dec_valid && (busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign busy_mask = busy_q;

`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_hold_q, stat_hold_d;
    logic [31:0] stat_full_q, stat_full_d;

    always_comb begin
        stat_hold_d = stat_hold_q;
        stat_full_d = stat_full_q;
        if (rw_hold && stat_hold_q != '1) begin
            stat_hold_d = stat_hold_q + 32'd1;
        end
        if (lu_valid && fifo_full && stat_full_q != '1) begin
            stat_full_d = stat_full_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hold_q <= '0;
            stat_full_q <= '0;
        end else begin
            stat_hold_q <= stat_hold_d;
            stat_full_q <= stat_full_d;
        end
    end

    assign stat_hold_cnt = stat_hold_q;
    assign stat_full_cnt = stat_full_q;
`endif

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Owns the single register-file write port behind the RW stage. Shares it between the in-order RW stage result and results from a long-latency unit (LU, e.g. mul/div). LU results are buffered in a small FIFO until the port is free. A pending-destination scoreboard drives a decode interlock. A starvation counter periodically holds the RW stage so buffered LU results drain.

Parameters:
FIFO_DEPTH, 4, LU result buffer entries (power of 2, >=2)
STARVE_LIMIT, 3, consecutive lost-grant cycles with FIFO non-empty before the RW stage is held for one cycle

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rw_is_wb  in  1  RW stage requests a write this cycle
rw_rd  in  4  RW destination (already muxed to 4'b1111 for call)
rw_data  in  32  RW write value
rw_hold  out  1  RW stage must hold its instruction this cycle; its write is not taken
lu_valid  in  1  LU result valid
lu_rd  in  4  LU destination
lu_data  in  32  LU result
lu_ready  out  1  FIFO not full
iss_valid  in  1  long-latency op issued this cycle
iss_rd  in  4  its destination
dec_rs1, dec_rs2, dec_rd  in  4 each  decode-stage operands
dec_valid  in  1  decode holds a valid instruction
dec_stall  out  1  interlock to decode
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  4  registered
rf_wdata  out  32  registered
busy_mask  out  16  scoreboard pending bits

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, scoreboard cleared, starve counter = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, busy_mask = 0. The same applies to reset asserted mid-operation: buffered LU results are discarded.
- rw_hold = (starve_cnt == STARVE_LIMIT) && fifo_nonempty. It depends on registered state only and has no combinational path from rw_is_wb.
- Grant per cycle:
  - rw_hold=1 → FIFO head.
  - Else rw_is_wb=1 → RW.
  - Else FIFO non-empty → FIFO head.
  - Else none.
- The winner is registered onto rf_we/rf_waddr/rf_wdata at the next edge (1-cycle latency). With no grant, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- starve_cnt:
  - Increments when the FIFO is non-empty and RW wins.
  - Resets to 0 when the FIFO head is granted or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- LU handshake: lu_ready = !full. Enqueue on lu_valid && lu_ready; there is no bypass.
  - Earliest path: enqueue at edge N, head granted in cycle N+1, rf_we high in cycle N+2.
  - Enqueue and dequeue may occur in the same cycle, including when full: dequeue first, so lu_ready stays 0 when full. A full FIFO accepts nothing even if draining.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with an extra pointer bit.
- Scoreboard:
  - Bit iss_rd is set on iss_valid.
  - Bit rd is cleared when a FIFO-head write of that rd is granted.
  - Set and clear of the same index in one cycle → bit stays set.
  - busy_mask is the register value.
- dec_stall = dec_valid && (busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd]). It is combinational from registered state. A clear takes effect the cycle after the grant.
- RW and FIFO-head writes to the same rd cannot coexist, because the interlock prevents it. The bench asserts this never happens.
- lu_valid with busy[lu_rd]=0 is illegal. The bench asserts this never happens.

Optional Feature:
WB_ARB_STATS_EN:
- Defined: adds 32-bit outputs stat_hold_cnt (cycles with rw_hold=1) and stat_full_cnt (cycles with lu_valid && !lu_ready). Both counters are reset by rst_n and saturate at all-ones.
- Undefined: neither port nor counter exists, and all other behaviour is identical.

Decomposition:
- Package wb_arb_pkg holds:
  - REG_ADDR_W=4, NUM_REGS=16, RA_REG=4'b1111.
  - Typedef wb_req_t {rd[3:0], data[31:0]}.
  - Enum grant_e {GNT_NONE, GNT_RW, GNT_LU}.
- Sub-module wb_result_fifo (parameterised depth, wb_req_t entries, push/pop/full/empty). The top level holds arbitration, the starve counter and the scoreboard.

Test Plan:
- Reset with rst_n=0 mid-stream after 3 LU enqueues → rf_we=0, busy_mask=0, lu_ready=1 immediately; no stale write after release.
- Single LU result: iss rd=5, then lu_valid rd=5 data=0xDEADBEEF with RW idle → rf_we=1, waddr=5, wdata=0xDEADBEEF exactly 2 cycles after enqueue; busy[5] clears the following cycle.
- Starvation: rw_is_wb=1 every cycle, one LU entry rd=7 → rw_hold=1 on the 4th cycle after enqueue-visible (STARVE_LIMIT=3), LU written; RW's held write appears next cycle.
- Full FIFO: iss rd=1..4, push 4 LU results with RW busy → lu_ready=0 on the 5th push; a stalled LU result is accepted only after a pop; stat_full_cnt counts stalled cycles when WB_ARB_STATS_EN is defined.
- Interlock: busy[9]=1, dec_rs2=9 → dec_stall=1 until the cycle after the rd=9 LU grant; dec_rd=9 also stalls.
- Set/clear collision: grant clears rd=3 while iss_valid rd=3 → busy[3] remains 1.
